frag_gen_lanes: RTL and testbench
=================================

FRAG_GEN_LANES -- requirements
Module: frag_gen_lanes

Interface
REQ-001 SHALL have parameters:
- NLANES, default 4: pixels per bundle; power of two, 1..16.
- W, default 32: signed edge-function width.
- CW, default 16: unsigned coordinate width.
- LG_FIFO, default 3: log2 of output FIFO depth in bundles.

REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the only clock; all state changes on its rising edge.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a triangle; sampled only in IDLE.
- xmin, xmax, ymin, ymax, in, CW each: inclusive bounding box.
- w0_00, w1_00, w2_00, in, W each: edge values at (xmin, ymin).
- a0, a1, a2, in, W each: per-edge increment for x+1.
- b0, b1, b2, in, W each: per-edge increment for y+1.
- tl, in, 3: per-edge top-left flag.
- pop_frag, in, 1: consumer accepts the head bundle.
- frag_val, out, 1: FIFO non-empty.
- frag_x, frag_y, out, CW each: lane-0 coordinate of the head bundle.
- frag_mask, out, NLANES: coverage; bit k = lane k.
- frag_w, out, 3*NLANES*W: edge values of the head bundle; lane k edge e at bits [(3k+e)*W +: W].
- busy, out, 1: high whenever state is not IDLE.
- done, out, 1: one-cycle completion pulse.

Function
REQ-003 SHALL implement states IDLE, SETUP, SCAN, NEXT_ROW, DRAIN.
REQ-004 IDLE with start=1 SHALL capture all inputs and go to SETUP; start in any other state SHALL be ignored.
REQ-005 SETUP SHALL:
- set row and current edge bases to w*_00 and x=xmin, y=ymin;
- compute per-edge lane offsets k*a_e by shift-add, without a multiplier;
- go to DRAIN if xmin>xmax or ymin>ymax, otherwise to SCAN.
REQ-006 In SCAN with FIFO not full, SHALL evaluate one bundle per cycle:
- lane k covers x+k;
- lane edge value w_e + k*a_e;
- lane inside iff each edge has w>0, or w==0 and tl[e]=0;
- lanes with x+k > xmax SHALL be cleared in the mask.
REQ-007 A bundle with non-zero mask SHALL be written to the FIFO at the end of its SCAN cycle; an all-zero bundle SHALL be discarded but still advances the scan.
REQ-008 After a bundle, if x+NLANES <= xmax, SHALL set x += NLANES and w_e += NLANES*a_e (shift), staying in SCAN.
REQ-009 Otherwise SHALL go to NEXT_ROW if y < ymax, or to DRAIN if y == ymax.
REQ-010 NEXT_ROW SHALL, in one cycle, set row base w_e += b_e, copy it to the current base, set x=xmin, y+=1, and return to SCAN.
REQ-011 In SCAN with FIFO full, SHALL hold all state with no evaluation and no push.
REQ-012 All edge arithmetic SHALL be W-bit two's complement, wrapping without saturation; coordinate arithmetic SHALL be CW+1 bits so that x+NLANES cannot wrap.
REQ-013 DRAIN SHALL wait for FIFO empty, then pulse done=1 for exactly one cycle in the same cycle it returns to IDLE.
REQ-014 FIFO depth SHALL be 2^LG_FIFO bundles, with full/empty derived from LG_FIFO+1-bit pointers.
REQ-015 FIFO outputs SHALL show the head entry; frag_val=1 iff the FIFO is non-empty.
REQ-016 pop_frag when empty SHALL be ignored.
REQ-017 Push and pop in the same cycle SHALL both take effect.
REQ-018 Push eligibility SHALL use the registered full flag, so a same-cycle pop does not unblock a push; there is no bypass path.
REQ-019 Latency: start high in cycle N SHALL make frag_val high no earlier than cycle N+3, with one bundle per cycle thereafter while unstalled.

Reset
REQ-020 rst low SHALL immediately clear:
- state to IDLE;
- FIFO pointers, so frag_val=0;
- done=0, busy=0;
- all datapath registers to 0.
REQ-021 Reset asserted mid-triangle SHALL discard all pending bundles, with no done pulse.
REQ-022 After rst deasserts, the first rising edge SHALL accept start.
REQ-023 FIFO storage need not be reset; outputs SHALL be qualified by frag_val.

Verification
REQ-024 NLANES=4, box x 0..5, y 0..1, all a=b=0, all w00=1, pop held 1 -> bundles in order:
- (0,0) mask 1111;
- (4,0) mask 0011;
- (0,1) mask 1111;
- (4,1) mask 0011;
- then one done pulse.
REQ-025 NLANES=4, box x 0..3, y 0..0, w0_00=-2, a0=1, w1=w2=1, other increments 0 -> one bundle, mask 1100, lane-2 w0=0, lane-3 w0=1.
REQ-026 Top-left rule, box 0..0 x 0..0, all w00=0:
- tl=000 -> one bundle, mask 0001;
- tl=001 -> no frag_val, done pulse.
REQ-027 LG_FIFO=1, box x 0..15, y 0..0, all w=1, pop=0 -> exactly 2 bundles queued, busy stays 1, no done; pop then released -> all 4 bundles arrive in order, then done.
REQ-028 Empty box xmin=5, xmax=4 -> done pulse at cycle N+3 from start, frag_val never high.
REQ-029 rst pulled low after 2 bundles queued -> frag_val=0 immediately, busy=0, no done; a following start runs cleanly.

Source files
------------

// File: rtl/frag_gen_lanes.sv
// Rasterizer fragment generator: scans a bounding box NLANES pixels per cycle and queues covered bundles.
// Latency: start in cycle N gives first frag_val no earlier than N+3, then one bundle per cycle.
// Backpressure: scan holds all state while the output FIFO is full; pop_frag drains the FIFO.
module frag_gen_lanes #(
    parameter int NLANES  = 4,
    parameter int W       = 32,
    parameter int CW      = 16,
    parameter int LG_FIFO = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CW-1:0]            xmin,
    input  logic [CW-1:0]            xmax,
    input  logic [CW-1:0]            ymin,
    input  logic [CW-1:0]            ymax,
    input  logic [W-1:0]             w0_00,
    input  logic [W-1:0]             w1_00,
    input  logic [W-1:0]             w2_00,
    input  logic [W-1:0]             a0,
    input  logic [W-1:0]             a1,
    input  logic [W-1:0]             a2,
    input  logic [W-1:0]             b0,
    input  logic [W-1:0]             b1,
    input  logic [W-1:0]             b2,
    input  logic [2:0]               tl,
    input  logic                     pop_frag,
    output logic                     frag_val,
    output logic [CW-1:0]            frag_x,
    output logic [CW-1:0]            frag_y,
    output logic [NLANES-1:0]        frag_mask,
    output logic [3*NLANES*W-1:0]    frag_w,
    output logic                     busy,
    output logic                     done
);

    localparam int LGN   = $clog2(NLANES);
    localparam int XW    = CW + 1;
    localparam int EW    = 3 * NLANES * W;
    localparam int ENW   = 2 * CW + NLANES + EW;
    localparam int DEPTH = 1 << LG_FIFO;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_SCAN     = 3'd2;
    localparam logic [2:0] S_NEXT_ROW = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;

    logic [2:0]          state;
    logic [CW-1:0]       xmin_r, xmax_r, ymin_r, ymax_r;
    logic [2:0]          tl_r;
    logic [W-1:0]        w00_r    [3];
    logic [W-1:0]        a_r      [3];
    logic [W-1:0]        b_r      [3];
    logic [W-1:0]        row_w    [3];
    logic [W-1:0]        cur_w    [3];
    logic [W-1:0]        lane_off [NLANES][3];
    logic [XW-1:0]       x_r, y_r;
    logic                done_r;

    logic [W-1:0]        w00_in [3];
    logic [W-1:0]        a_in   [3];
    logic [W-1:0]        b_in   [3];

    logic [W-1:0]        lane_w [NLANES][3];
    logic [NLANES-1:0]   mask;
    logic [EW-1:0]       w_pack;

    logic [ENW-1:0]      mem [DEPTH];
    logic [LG_FIFO:0]    wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, push, pop;
    logic [ENW-1:0]      head;

    assign w00_in[0] = w0_00;
    assign w00_in[1] = w1_00;
    assign w00_in[2] = w2_00;
    assign a_in[0]   = a0;
    assign a_in[1]   = a1;
    assign a_in[2]   = a2;
    assign b_in[0]   = b0;
    assign b_in[1]   = b1;
    assign b_in[2]   = b2;

    // k*a built from shifted copies of a, one per set bit of k (k < 32)
    function automatic logic [W-1:0] times_k(input logic [W-1:0] a, input int k);
        logic [W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            if (k[i]) acc = acc + (a << i);
        end
        return acc;
    endfunction

    // Per-lane edge values, top-left coverage test and right-edge clipping
    always_comb begin
        logic cov;
        mask   = '0;
        w_pack = '0;
        for (int k = 0; k < NLANES; k++) begin
            cov = 1'b1;
            for (int e = 0; e < 3; e++) begin
                lane_w[k][e] = cur_w[e] + lane_off[k][e];
                w_pack[(3*k+e)*W +: W] = lane_w[k][e];
                cov = cov && (($signed(lane_w[k][e]) > 0) ||
                              ((lane_w[k][e] == '0) && !tl_r[e]));
            end
            mask[k] = cov && ((x_r + XW'(k)) <= {1'b0, xmax_r});
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[LG_FIFO] != rd_ptr[LG_FIFO]) &&
                        (wr_ptr[LG_FIFO-1:0] == rd_ptr[LG_FIFO-1:0]);
    // Full comes straight from registered pointers, so a pop never frees a slot for the same cycle's push
    assign push       = (state == S_SCAN) && !fifo_full && (mask != '0);
    assign pop        = pop_frag && !fifo_empty;

    // Scan controller: capture, setup, bundle walk, row step, drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            xmin_r <= '0;
            xmax_r <= '0;
            ymin_r <= '0;
            ymax_r <= '0;
            tl_r   <= '0;
            x_r    <= '0;
            y_r    <= '0;
            done_r <= 1'b0;
            for (int e = 0; e < 3; e++) begin
                w00_r[e] <= '0;
                a_r[e]   <= '0;
                b_r[e]   <= '0;
                row_w[e] <= '0;
                cur_w[e] <= '0;
                for (int k = 0; k < NLANES; k++) lane_off[k][e] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        xmin_r <= xmin;
                        xmax_r <= xmax;
                        ymin_r <= ymin;
                        ymax_r <= ymax;
                        tl_r   <= tl;
                        for (int e = 0; e < 3; e++) begin
                            w00_r[e] <= w00_in[e];
                            a_r[e]   <= a_in[e];
                            b_r[e]   <= b_in[e];
                        end
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    x_r <= {1'b0, xmin_r};
                    y_r <= {1'b0, ymin_r};
                    for (int e = 0; e < 3; e++) begin
                        row_w[e] <= w00_r[e];
                        cur_w[e] <= w00_r[e];
                        for (int k = 0; k < NLANES; k++) lane_off[k][e] <= times_k(a_r[e], k);
                    end
                    if ((xmin_r > xmax_r) || (ymin_r > ymax_r)) state <= S_DRAIN;
                    else                                        state <= S_SCAN;
                end
                S_SCAN: begin
                    if (!fifo_full) begin
                        if ((x_r + XW'(NLANES)) <= {1'b0, xmax_r}) begin
                            x_r <= x_r + XW'(NLANES);
                            for (int e = 0; e < 3; e++) cur_w[e] <= cur_w[e] + (a_r[e] << LGN);
                        end else if (y_r < {1'b0, ymax_r}) begin
                            state <= S_NEXT_ROW;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_NEXT_ROW: begin
                    for (int e = 0; e < 3; e++) begin
                        row_w[e] <= row_w[e] + b_r[e];
                        cur_w[e] <= row_w[e] + b_r[e];
                    end
                    x_r   <= {1'b0, xmin_r};
                    y_r   <= y_r + XW'(1);
                    state <= S_SCAN;
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        done_r <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers; push and pop may both happen in one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage, left unreset; everything read out is qualified by frag_val
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[LG_FIFO-1:0]] <= {y_r[CW-1:0], x_r[CW-1:0], mask, w_pack};
    end

    assign head      = mem[rd_ptr[LG_FIFO-1:0]];
    assign frag_val  = !fifo_empty;
    assign frag_w    = head[EW-1:0];
    assign frag_mask = head[EW +: NLANES];
    assign frag_x    = head[EW+NLANES +: CW];
    assign frag_y    = head[EW+NLANES+CW +: CW];
    assign busy      = (state != S_IDLE);
    assign done      = done_r;

endmodule

// File: tb/tb_frag_gen_lanes.sv
// Directed bench for frag_gen_lanes (NLANES=4, 2-deep FIFO).
// Inputs change 1 time unit after the rising edge; bundles and done pulses are sampled on the falling edge.
// Pops are only recorded when pop_frag is high at the falling edge, i.e. when the next rising edge consumes the head.
module tb_frag_gen_lanes;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   xmin, xmax, ymin, ymax;
    logic [31:0]   w0_00, w1_00, w2_00;
    logic [31:0]   a0, a1, a2, b0, b1, b2;
    logic [2:0]    tl;
    logic          pop_frag;
    logic          frag_val;
    logic [15:0]   frag_x, frag_y;
    logic [3:0]    frag_mask;
    logic [383:0]  frag_w;
    logic          busy;
    logic          done;

    frag_gen_lanes #(.NLANES(4), .W(32), .CW(16), .LG_FIFO(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
        .w0_00(w0_00), .w1_00(w1_00), .w2_00(w2_00),
        .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
        .tl(tl), .pop_frag(pop_frag),
        .frag_val(frag_val), .frag_x(frag_x), .frag_y(frag_y),
        .frag_mask(frag_mask), .frag_w(frag_w),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;

    int            cyc      = 0;
    int            n_got    = 0;
    int            val_cnt  = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            l_cyc    = 0;
    logic [15:0]   got_x [64];
    logic [15:0]   got_y [64];
    logic [3:0]    got_m [64];
    logic [383:0]  got_w [64];

    // Falling-edge monitor: bundles consumed, cycles with frag_val, done pulses
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frag_val && pop_frag && n_got < 64) begin
            got_x[n_got] = frag_x;
            got_y[n_got] = frag_y;
            got_m[n_got] = frag_mask;
            got_w[n_got] = frag_w;
            n_got = n_got + 1;
        end
        if (frag_val) val_cnt = val_cnt + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; start is seen by the next rising edge (cycle N ends there)
    task automatic launch(input logic [15:0] x0, input logic [15:0] x1,
                          input logic [15:0] y0, input logic [15:0] y1,
                          input logic [31:0] w0v, input logic [31:0] w1v, input logic [31:0] w2v,
                          input logic [31:0] a0v, input logic [2:0] tlv);
        xmin = x0; xmax = x1; ymin = y0; ymax = y1;
        w0_00 = w0v; w1_00 = w1v; w2_00 = w2v;
        a0 = a0v; a1 = '0; a2 = '0; b0 = '0; b1 = '0; b2 = '0;
        tl = tlv;
        start = 1'b1;
        l_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int base;
        base = done_cnt;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (done_cnt != base) break;
        end
        if (done_cnt == base) check("done_timeout", 0, 1);
    endtask

    task automatic chk_bundle(input string tag, input int idx,
                              input logic [15:0] ex, input logic [15:0] ey, input logic [3:0] em);
        check({tag, "_x"}, got_x[idx], ex);
        check({tag, "_y"}, got_y[idx], ey);
        check({tag, "_mask"}, got_m[idx], em);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb, db, vb;
        logic [383:0] wv;
        logic [15:0]  ex_x [4];
        logic [15:0]  ex_y [4];
        logic [3:0]   ex_m [4];

        rst = 1'b0; start = 1'b0; pop_frag = 1'b0;
        xmin = '0; xmax = '0; ymin = '0; ymax = '0;
        w0_00 = '0; w1_00 = '0; w2_00 = '0;
        a0 = '0; a1 = '0; a2 = '0; b0 = '0; b1 = '0; b2 = '0; tl = '0;
        repeat (3) step();
        check("rst_frag_val", frag_val, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        step();

        // 6x2 box, all edges constant 1: two full bundles and two 2-lane tails
        pop_frag = 1'b1;
        nb = n_got; db = done_cnt;
        launch(16'd0, 16'd5, 16'd0, 16'd1, 32'd1, 32'd1, 32'd1, 32'd0, 3'b000);
        check("busy_after_start", busy, 1);
        step();
        check("lat_n2_no_val", frag_val, 0);
        step();
        check("lat_n3_val", frag_val, 1);
        wait_done(60);
        repeat (3) step();
        check("box6x2_count", n_got - nb, 4);
        ex_x = '{16'd0, 16'd4, 16'd0, 16'd4};
        ex_y = '{16'd0, 16'd0, 16'd1, 16'd1};
        ex_m = '{4'b1111, 4'b0011, 4'b1111, 4'b0011};
        for (int i = 0; i < 4; i++) chk_bundle($sformatf("box6x2_b%0d", i), nb + i, ex_x[i], ex_y[i], ex_m[i]);
        wv = got_w[nb];
        check("box6x2_l3_e2", wv[11*32 +: 32], 32'd1);
        check("box6x2_done_once", done_cnt - db, 1);
        check("box6x2_idle", busy, 0);

        // Edge 0 ramps -2,-1,0,1 across the lanes; zero is inside with tl clear
        nb = n_got;
        launch(16'd0, 16'd3, 16'd0, 16'd0, 32'hFFFF_FFFE, 32'd1, 32'd1, 32'd1, 3'b000);
        wait_done(40);
        check("ramp_count", n_got - nb, 1);
        check("ramp_mask", got_m[nb], 4'b1100);
        wv = got_w[nb];
        check("ramp_l0_w0", wv[0*32 +: 32], 32'hFFFF_FFFE);
        check("ramp_l2_w0", wv[6*32 +: 32], 32'd0);
        check("ramp_l3_w0", wv[9*32 +: 32], 32'd1);
        check("ramp_l1_w1", wv[4*32 +: 32], 32'd1);

        // Single pixel on all three edges: top-left flag decides coverage
        nb = n_got;
        launch(16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000);
        wait_done(40);
        check("tl000_count", n_got - nb, 1);
        chk_bundle("tl000", nb, 16'd0, 16'd0, 4'b0001);

        nb = n_got; vb = val_cnt; db = done_cnt;
        launch(16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b001);
        wait_done(40);
        check("tl001_no_val", val_cnt - vb, 0);
        check("tl001_done", done_cnt - db, 1);

        // Empty box: done lands in cycle N+3, nothing queued
        vb = val_cnt; db = done_cnt;
        launch(16'd5, 16'd4, 16'd0, 16'd0, 32'd1, 32'd1, 32'd1, 32'd0, 3'b000);
        wait_done(40);
        check("empty_done_cyc", done_cyc - l_cyc, 4);
        check("empty_no_val", val_cnt - vb, 0);
        check("empty_done_once", done_cnt - db, 1);

        // 16-wide row against a 2-deep FIFO with no consumer, then release
        pop_frag = 1'b0;
        nb = n_got; db = done_cnt;
        launch(16'd0, 16'd15, 16'd0, 16'd0, 32'd1, 32'd1, 32'd1, 32'd0, 3'b000);
        repeat (20) step();
        check("stall_val", frag_val, 1);
        check("stall_busy", busy, 1);
        check("stall_no_done", done_cnt - db, 0);
        check("stall_head_x", frag_x, 16'd0);
        pop_frag = 1'b1;
        wait_done(60);
        check("stall_count", n_got - nb, 4);
        for (int i = 0; i < 4; i++) chk_bundle($sformatf("stall_b%0d", i), nb + i, 16'(4 * i), 16'd0, 4'b1111);
        check("stall_done_once", done_cnt - db, 1);

        // Reset mid-triangle with bundles queued, then a clean run
        pop_frag = 1'b0;
        db = done_cnt;
        launch(16'd0, 16'd15, 16'd0, 16'd0, 32'd1, 32'd1, 32'd1, 32'd0, 3'b000);
        repeat (10) step();
        check("pre_rst_val", frag_val, 1);
        rst = 1'b0;
        #1;
        check("rst_mid_val", frag_val, 0);
        check("rst_mid_busy", busy, 0);
        repeat (3) step();
        check("rst_mid_no_done", done_cnt - db, 0);
        pop_frag = 1'b1;
        rst = 1'b1;
        nb = n_got; db = done_cnt;
        launch(16'd0, 16'd3, 16'd0, 16'd0, 32'd1, 32'd1, 32'd1, 32'd0, 3'b000);
        wait_done(40);
        check("post_rst_count", n_got - nb, 1);
        chk_bundle("post_rst", nb, 16'd0, 16'd0, 4'b1111);
        check("post_rst_done", done_cnt - db, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
